// File: rtl/cpu_axi_pkg.sv
// Shared encodings for the CPU-to-AXI bridge: FSM states, transaction owner
// and the fixed single-beat AXI transfer attributes.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Every transfer is one 32-bit beat.
  localparam logic [3:0] LEN0       = 4'd0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/sram_axi_bridge.sv
// Merges the CPU instruction and data SRAM-like ports onto one AXI master,
// one transaction in flight, data port winning any same-cycle contention.
module sram_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  state_t      w_next;
  owner_t      r_owner;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awDone;
  logic        r_wDone;
  logic [31:0] r_instRdata;
  logic [31:0] r_dataRdata;
  logic        r_instDataOk;
  logic        r_dataDataOk;
  logic        w_instAddrOk;
  logic        w_dataAddrOk;
  logic        w_awDoneNow;
  logic        w_wDoneNow;
  logic [3:0]  w_arid;

  assign w_awDoneNow = r_awDone | awready;
  assign w_wDoneNow  = r_wDone  | wready;
  assign w_arid      = (r_owner == OWN_DATA) ? DATA_ID : INST_ID;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Acceptance is gated by reset so no addr_ok escapes while reset is held.
  always_comb begin
    w_next       = r_state;
    w_instAddrOk = 1'b0;
    w_dataAddrOk = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset) begin
          w_next = S_IDLE;
        end else if (data_req) begin
          w_dataAddrOk = 1'b1;
          w_next       = data_wr ? S_AW_W : S_AR;
        end else if (inst_req) begin
          w_instAddrOk = 1'b1;
          w_next       = S_AR;
        end
      end
      S_AR:    if (arready) w_next = S_R;
      S_R:     if (rvalid) w_next = S_IDLE;
      S_AW_W:  if (w_awDoneNow && w_wDoneNow) w_next = S_B;
      S_B:     if (bvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_INST;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awDone     <= 1'b0;
      r_wDone      <= 1'b0;
      r_instRdata  <= '0;
      r_dataRdata  <= '0;
      r_instDataOk <= 1'b0;
      r_dataDataOk <= 1'b0;
    end else begin
      r_instDataOk <= 1'b0;
      r_dataDataOk <= 1'b0;
      if (w_dataAddrOk) begin
        r_owner  <= OWN_DATA;
        r_addr   <= data_addr;
        r_wdata  <= data_wdata;
        r_wstrb  <= data_size;
        r_awDone <= 1'b0;
        r_wDone  <= 1'b0;
      end else if (w_instAddrOk) begin
        r_owner  <= OWN_INST;
        r_addr   <= inst_addr;
      end
      if (r_state == S_AW_W) begin
        if (awready) r_awDone <= 1'b1;
        if (wready)  r_wDone  <= 1'b1;
      end
      // Read data lands in the owner's register; the ok pulse follows one cycle later.
      if (r_state == S_R && rvalid) begin
        if (r_owner == OWN_INST) begin
          r_instRdata  <= rdata;
          r_instDataOk <= 1'b1;
        end else begin
          r_dataRdata  <= rdata;
          r_dataDataOk <= 1'b1;
        end
      end
      if (r_state == S_B && bvalid) r_dataDataOk <= 1'b1;
    end
  end

  assign inst_addr_ok = w_instAddrOk;
  assign data_addr_ok = w_dataAddrOk;
  assign inst_data_ok = r_instDataOk;
  assign data_data_ok = r_dataDataOk;
  assign inst_rdata   = r_instRdata;
  assign data_rdata   = r_dataRdata;

  assign arid    = w_arid;
  assign araddr  = r_addr;
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);
  assign awaddr  = r_addr;
  assign awvalid = (r_state == S_AW_W) && !r_awDone;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wvalid  = (r_state == S_AW_W) && !r_wDone;
  assign bready  = (r_state == S_B);

  a_ridMatch: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_R && rvalid) |-> (rid == w_arid));

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: the bench plays the AXI slave with
// fixed cycle timing and a scoreboard matches every data_ok pulse.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;

  int numChecks = 0;
  int numErrors = 0;
  logic [31:0] instQ[$];
  logic [31:0] dataQ[$];

  sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every data_ok pulse must match an expectation pushed at acceptance.
  always @(negedge clk) begin
    if (!reset && inst_data_ok) begin
      numChecks++;
      if (instQ.size() == 0) begin
        numErrors++;
        $display("[TB] FAIL inst_data_ok_unexpected rdata=%h", inst_rdata);
      end else begin
        logic [31:0] exp;
        exp = instQ.pop_front();
        if (inst_rdata !== exp) begin
          numErrors++;
          $display("[TB] FAIL inst_rdata got=%h exp=%h", inst_rdata, exp);
        end
      end
    end
    if (!reset && data_data_ok) begin
      numChecks++;
      if (dataQ.size() == 0) begin
        numErrors++;
        $display("[TB] FAIL data_data_ok_unexpected rdata=%h", data_rdata);
      end else begin
        logic [31:0] exp;
        exp = dataQ.pop_front();
        if (data_rdata !== exp) begin
          numErrors++;
          $display("[TB] FAIL data_rdata got=%h exp=%h", data_rdata, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; arready = 0; rid = 0; rdata = 0;
    rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    repeat (2) tick();
    numChecks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok,
         inst_addr_ok, data_addr_ok} !== 9'b0) begin
      numErrors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {arvalid, rready, awvalid,
               wvalid, bready, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok});
    end
    numChecks++;
    if ({araddr, wdata, wstrb, inst_rdata, data_rdata} !== '0) begin
      numErrors++;
      $display("[TB] FAIL reset_regs araddr=%h wdata=%h wstrb=%b exp=0", araddr, wdata, wstrb);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_inst_read();
    inst_req = 1; inst_addr = 32'hBFC0_0000; arready = 1;
    #1;
    numChecks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL inst_accept inst_ok=%b data_ok=%b exp=1/0", inst_addr_ok, data_addr_ok);
    end
    instQ.push_back(32'h3C1D_BFC0);
    tick();
    inst_req = 0;
    numChecks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || arid !== 4'd0) begin
      numErrors++;
      $display("[TB] FAIL inst_ar arvalid=%b araddr=%h arid=%0d exp=1/bfc00000/0", arvalid, araddr, arid);
    end
    tick();
    arready = 0;
    numChecks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL inst_r_phase arvalid=%b rready=%b exp=0/1", arvalid, rready);
    end
    rvalid = 1; rid = 4'd0; rdata = 32'h3C1D_BFC0;
    tick();
    rvalid = 0;
    numChecks++;
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL inst_data_ok_latency inst=%b data=%b exp=1/0", inst_data_ok, data_data_ok);
    end
    tick();
    numChecks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h3C1D_BFC0) begin
      numErrors++;
      $display("[TB] FAIL inst_hold ok=%b rdata=%h exp=0/3c1dbfc0", inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_simultaneous();
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_1000;
    #1;
    numChecks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL priority data_ok=%b inst_ok=%b exp=1/0", data_addr_ok, inst_addr_ok);
    end
    dataQ.push_back(32'h1122_3344);
    tick();
    data_req = 0; arready = 1;
    numChecks++;
    if (arid !== 4'd1 || araddr !== 32'h8000_1000 || inst_addr_ok !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL data_ar arid=%0d araddr=%h inst_ok=%b exp=1/80001000/0", arid, araddr, inst_addr_ok);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h1122_3344;
    tick();
    rvalid = 0;
    #1;
    numChecks++;
    if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL overlap data_data_ok=%b inst_addr_ok=%b exp=1/1", data_data_ok, inst_addr_ok);
    end
    instQ.push_back(32'hAABB_CCDD);
    tick();
    inst_req = 0; arready = 1;
    numChecks++;
    if (arid !== 4'd0 || araddr !== 32'hBFC0_0004) begin
      numErrors++;
      $display("[TB] FAIL inst_after_data arid=%0d araddr=%h exp=0/bfc00004", arid, araddr);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'hAABB_CCDD;
    tick();
    rvalid = 0;
    tick();
  endtask

  task automatic test_write_reorder();
    data_req = 1; data_wr = 1; data_size = 4'b0011;
    data_addr = 32'h8000_2000; data_wdata = 32'hDEAD_BEEF;
    #1;
    numChecks++;
    if (data_addr_ok !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL wr_accept got=%b exp=1", data_addr_ok);
    end
    dataQ.push_back(32'h1122_3344);
    tick();
    data_req = 0; data_wr = 0;
    numChecks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b0011 ||
        wdata !== 32'hDEAD_BEEF || awaddr !== 32'h8000_2000 || arvalid !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL wr_issue aw=%b w=%b strb=%b wdata=%h awaddr=%h ar=%b exp=1/1/0011/deadbeef/80002000/0",
               awvalid, wvalid, wstrb, wdata, awaddr, arvalid);
    end
    wready = 1;
    tick();
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) awready = 1;
      numChecks++;
      if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin
        numErrors++;
        $display("[TB] FAIL wr_aw_hold%0d wvalid=%b awvalid=%b bready=%b exp=0/1/0", i, wvalid, awvalid, bready);
      end
      tick();
    end
    awready = 0;
    numChecks++;
    if (bready !== 1'b1 || awvalid !== 1'b0 || data_data_ok !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL wr_b bready=%b awvalid=%b data_ok=%b exp=1/0/0", bready, awvalid, data_data_ok);
    end
    bvalid = 1;
    tick();
    bvalid = 0;
    numChecks++;
    if (data_data_ok !== 1'b1 || bready !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL wr_done data_ok=%b bready=%b exp=1/0", data_data_ok, bready);
    end
    tick();
  endtask

  task automatic test_ar_stall();
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    #1;
    numChecks++;
    if (inst_addr_ok !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL stall_accept got=%b exp=1", inst_addr_ok);
    end
    instQ.push_back(32'h0BAD_F00D);
    tick();
    data_req = 1; data_wr = 0; data_addr = 32'h8000_5000; arready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      numChecks++;
      if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0100 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        numErrors++;
        $display("[TB] FAIL stall%0d arvalid=%b araddr=%h inst_ok=%b data_ok=%b exp=1/bfc00100/0/0",
                 i, arvalid, araddr, inst_addr_ok, data_addr_ok);
      end
      tick();
    end
    inst_req = 0; data_req = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 0;
    tick();
  endtask

  task automatic test_reset_in_r();
    data_req = 1; data_wr = 0; data_addr = 32'h8000_3000;
    tick();
    data_req = 0; arready = 1;
    tick();
    arready = 0;
    numChecks++;
    if (rready !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL rst_enter_r rready=%b exp=1", rready);
    end
    #2 reset = 1'b1;
    #1;
    numChecks++;
    if ({rready, arvalid, inst_data_ok, data_data_ok} !== 4'b0 ||
        {araddr, inst_rdata, data_rdata} !== '0) begin
      numErrors++;
      $display("[TB] FAIL rst_async rready=%b arvalid=%b araddr=%h inst_rdata=%h data_rdata=%h exp=0",
               rready, arvalid, araddr, inst_rdata, data_rdata);
    end
    tick();
    reset = 1'b0;
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    #1;
    numChecks++;
    if (inst_addr_ok !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL rst_reaccept got=%b exp=1", inst_addr_ok);
    end
    instQ.push_back(32'h1234_5678);
    tick();
    inst_req = 0; arready = 1;
    numChecks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0200 || arid !== 4'd0) begin
      numErrors++;
      $display("[TB] FAIL rst_ar arvalid=%b araddr=%h arid=%0d exp=1/bfc00200/0", arvalid, araddr, arid);
    end
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h1234_5678;
    tick();
    rvalid = 0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_simultaneous();
    test_write_reorder();
    test_ar_stall();
    test_reset_in_r();
    numChecks++;
    if (instQ.size() != 0 || dataQ.size() != 0) begin
      numErrors++;
      $display("[TB] FAIL scoreboard_drain inst_left=%0d data_left=%0d exp=0/0", instQ.size(), dataQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Converts the CPU's two SRAM-like ports (instruction, data) into one AXI3-subset master port.
- Sits directly downstream of the CPU top: it consumes the `inst_*` and `data_*` req/addr_ok/data_ok traffic and returns read data to it.
- Allows one outstanding transaction at a time.
- The data port has priority over the instruction port.

Parameters:
- INST_ID, 4'd0, AXI ID used for instruction reads
- DATA_ID, 4'd1, AXI ID used for data reads and writes

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  instruction read request; the instruction port is read-only
- inst_addr  in  32  instruction byte address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid, one-cycle pulse
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  4  byte-enable mask for writes; ignored on reads
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  read data valid or write complete, one-cycle pulse
- data_rdata  out  32  data read data
- arid  out  4  read ID
- araddr  out  32  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rid  in  4  read response ID
- rdata  in  32  read data
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write byte strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- AXI fixed settings: every transaction is single-beat, 32-bit (len 0, size 2'b10); ID/size/len/burst/lock/cache/prot tie-offs are driven at top level.
- Reset: state IDLE; all valid/ready/ok outputs 0; address, data and strobe registers 0.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE, acceptance:
  - If data_req: data_addr_ok=1 combinationally. Latch addr, wr, wdata, and strobe = data_size, with owner = DATA.
  - Otherwise, if inst_req: inst_addr_ok=1 and latch inst_addr with owner = INST.
  - Next state: AR for a read, AW_W for a write.
  - Both requests in the same cycle: data is accepted; inst_addr_ok stays 0.
- AR:
  - arvalid=1, araddr = latched address, arid = INST_ID or DATA_ID.
  - Leave to R on arvalid && arready. Values stay stable while stalled.
- R:
  - rready=1.
  - On rvalid: capture rdata into the owner's rdata register and pulse that owner's data_ok next cycle (one-cycle latency). Return to IDLE.
  - The rid value is checked by assertion only.
- AW_W:
  - awvalid and wvalid asserted together. Each drops independently once its own handshake completes.
  - Move to B once both have completed, in any order or in the same cycle.
- B:
  - bready=1.
  - On bvalid: pulse data_data_ok next cycle, return to IDLE. bresp is ignored.
- Accept-and-return overlap: a new request may be accepted in IDLE in the same cycle that the previous data_ok pulse is high.
- No acceptance outside IDLE: addr_ok is 0 in every other state.
- Read data hold: inst_rdata and data_rdata hold their last value until the next capture.
- Reset mid-transaction: all state clears immediately. No AXI cleanup is attempted; the slave is reset by the same signal.

Decomposition:
- Shared package cpu_axi_pkg:
  - state encoding localparams (IDLE/AR/R/AW_W/B)
  - owner encoding (INST/DATA)
  - AXI constants (LEN0, SIZE_WORD, BURST_INCR)
- No sub-module; single FSM plus datapath registers.

Test Plan:
- Single instruction read:
  - Stimulus: inst_req=1, addr 0xBFC00000; arready=1 immediately; rvalid with 0x3C1DBFC0 two cycles later.
  - Response: inst_addr_ok in cycle 0; arvalid for 1 cycle; inst_data_ok one cycle after rvalid with inst_rdata=0x3C1DBFC0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (read, 0x80001000) both high in the same cycle.
  - Response: data_addr_ok=1 and inst_addr_ok=0; arid=1. After data_data_ok, the instruction request is accepted with arid=0.
- Data write with reordered handshakes:
  - Stimulus: data write, size 4'b0011, wdata 0xDEADBEEF; wready 3 cycles before awready.
  - Response: wvalid drops after its handshake; awvalid held until awready; wstrb=0011; data_data_ok one cycle after bvalid.
- arready stall:
  - Stimulus: arready low for 5 cycles.
  - Response: arvalid and araddr stable throughout; no addr_ok to either port during the stall.
- Reset during R state:
  - Stimulus: assert reset while in R.
  - Response: all outputs 0 asynchronously; the next request after reset is accepted normally.
